// File: rtl/popcount_preimage_gen.sv
// popcount_preimage_gen: streams every N-bit vector of popcount k
// in ascending order, one beat per valid/ready handshake.
module popcount_preimage_gen #(
  parameter int N  = 10,
  parameter int CW = $clog2(N+1),
  parameter int IW = N
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [CW-1:0] k,
  output logic          busy,
  output logic          err,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_vec,
  output logic [IW-1:0] out_index,
  output logic          out_last,
  output logic          done
);

  localparam int W1 = N + 1;
  localparam logic [CW-1:0] NK = CW'(N);

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  state_e        state_q, state_d;
  logic [W1-1:0] x_q, x_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CW-1:0] k_q, k_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic [W1-1:0] c_w, r_w, gos_w;
  logic [CW-1:0] tz_w;
  logic [W1-1:0] ones_in_w, ones_q_w, last_w;
  logic          is_last_w;

  // Next vector with the same popcount (Gosper, shift in place of divide)
  always_comb begin
    c_w  = x_q & (~x_q + W1'(1));
    r_w  = x_q + c_w;
    tz_w = '0;
    for (int i = N; i >= 0; i--) begin
      if (c_w[i]) tz_w = CW'(i);
    end
    gos_w = (((r_w ^ x_q) >> 2) >> tz_w) | r_w;
  end

  assign ones_in_w = (W1'(1) << k) - W1'(1);
  assign ones_q_w  = (W1'(1) << k_q) - W1'(1);
  assign last_w    = ones_q_w << (NK - k_q);
  assign is_last_w = (x_q == last_w);

  // Next-state: accept requests in IDLE, step the sequence in RUN
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    idx_d   = idx_q;
    k_d     = k_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (k > NK) begin
            err_d = 1'b1;
          end else begin
            k_d     = k;
            x_d     = ones_in_w;
            idx_d   = '0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (out_ready) begin
          if (is_last_w) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            x_d   = gos_w;
            idx_d = idx_q + IW'(1);
          end
        end
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      idx_q   <= '0;
      k_q     <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      idx_q   <= idx_d;
      k_q     <= k_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign out_valid = (state_q == RUN);
  assign out_vec   = x_q[N-1:0];
  assign out_index = idx_q;
  assign out_last  = (state_q == RUN) && is_last_w;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_popcount_preimage_gen.sv
// tb_popcount_preimage_gen: random-ready bench with an enumeration
// model of each popcount class, checked every cycle.
module tb_popcount_preimage_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] k;
  logic       busy, err, out_valid, out_ready, out_last, done;
  logic [9:0] out_vec;
  logic [9:0] out_index;

  popcount_preimage_gen dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .k         (k),
    .busy      (busy),
    .err       (err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_vec   (out_vec),
    .out_index (out_index),
    .out_last  (out_last),
    .done      (done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  int exp_q[$];
  int m_busy = 0;
  int m_pos  = 0;
  int m_k    = 0;
  int m_done = 0;
  int m_err  = 0;
  int prev_stall = 0;
  int prev_vec   = 0;
  int prev_idx   = 0;
  int n_hs   = 0;
  int n_done = 0;
  int last_idx = 0;
  int last_vec = 0;
  int seen_cnt [1024];

  task automatic chk(string name, int act, int expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Model: the class is simply every value with the right popcount, ascending
  function automatic void build(int kk);
    exp_q.delete();
    for (int v = 0; v < 1024; v++) begin
      if ($countones(v) == kk) exp_q.push_back(v);
    end
  endfunction

  // Compare process: outputs checked on every falling edge
  always @(negedge clk) begin
    int nd, ne;
    if (!rst_n) begin
      chk("rst_busy", int'(busy), 0);
      chk("rst_valid", int'(out_valid), 0);
      chk("rst_vec", int'(out_vec), 0);
      chk("rst_done", int'(done), 0);
      m_busy = 0; m_done = 0; m_err = 0; prev_stall = 0;
    end else begin
      chk("busy", int'(busy), m_busy);
      chk("valid", int'(out_valid), m_busy);
      chk("done", int'(done), m_done);
      chk("err", int'(err), m_err);
      if (done) n_done++;
      nd = 0;
      ne = 0;
      if (m_busy != 0) begin
        chk("vec", int'(out_vec), exp_q[m_pos]);
        chk("index", int'(out_index), m_pos);
        chk("last", int'(out_last), int'(m_pos == exp_q.size() - 1));
        chk("popcnt", $countones(out_vec), m_k);
        if (prev_stall != 0) begin
          chk("hold_vec", int'(out_vec), prev_vec);
          chk("hold_idx", int'(out_index), prev_idx);
        end
        prev_stall = int'(!out_ready);
        prev_vec   = int'(out_vec);
        prev_idx   = int'(out_index);
        if (out_ready) begin
          n_hs++;
          seen_cnt[out_vec]++;
          last_idx = int'(out_index);
          last_vec = int'(out_vec);
          if (m_pos == exp_q.size() - 1) begin
            m_busy = 0;
            nd = 1;
          end else begin
            m_pos++;
          end
        end
      end else begin
        prev_stall = 0;
        if (start) begin
          if (k > 4'd10) begin
            ne = 1;
          end else begin
            build(int'(k));
            m_k = int'(k);
            m_pos = 0;
            m_busy = 1;
          end
        end
      end
      m_done = nd;
      m_err  = ne;
    end
  end

  // Caller sits 2 time units after a rising edge
  task automatic start_class(int kk);
    start = 1'b1;
    k = 4'(kk);
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic wait_class(int rnd, int spur, int budget);
    int cyc = 0;
    while (m_busy != 0 && cyc < budget) begin
      out_ready = (rnd != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      start = 1'b0;
      if (spur != 0 && $urandom_range(0, 3) == 0) begin
        start = 1'b1;
        k = 4'($urandom_range(0, 15));
      end
      @(posedge clk); #2;
      cyc++;
    end
    start = 1'b0;
    if (m_busy != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: still busy after %0d cycles", budget);
    end
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk); #2;
    end
  endtask

  initial begin
    int bad;
    rst_n = 1'b0;
    start = 1'b0;
    k = '0;
    out_ready = 1'b0;
    idle(2);
    chk("reset_idx", int'(out_index), 0);
    chk("reset_last", int'(out_last), 0);
    chk("reset_err", int'(err), 0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    idle(2);

    build(3);
    chk("model_k3_size", exp_q.size(), 120);
    chk("model_k3_0", exp_q[0], 'h007);
    chk("model_k3_1", exp_q[1], 'h00B);
    chk("model_k3_2", exp_q[2], 'h00D);
    chk("model_k3_end", exp_q[119], 'h380);
    n_hs = 0;
    n_done = 0;
    start_class(3);
    wait_class(0, 0, 500);
    idle(2);
    chk("k3_beats", n_hs, 120);
    chk("k3_last_idx", last_idx, 119);
    chk("k3_last_vec", last_vec, 'h380);
    chk("k3_done_cnt", n_done, 1);

    n_hs = 0;
    start_class(0);
    chk("k0_valid", int'(out_valid), 1);
    chk("k0_vec", int'(out_vec), 0);
    chk("k0_last", int'(out_last), 1);
    wait_class(0, 0, 20);
    idle(2);
    chk("k0_beats", n_hs, 1);

    n_hs = 0;
    start_class(10);
    chk("k10_vec", int'(out_vec), 'h3FF);
    chk("k10_last", int'(out_last), 1);
    wait_class(0, 0, 20);
    idle(2);
    chk("k10_beats", n_hs, 1);

    start_class(11);
    chk("k11_err", int'(err), 1);
    chk("k11_busy", int'(busy), 0);
    idle(1);
    chk("k11_err_gone", int'(err), 0);
    idle(3);

    build(5);
    chk("model_k5_size", exp_q.size(), 252);
    n_hs = 0;
    start_class(5);
    wait_class(1, 0, 3000);
    idle(2);
    chk("k5_beats", n_hs, 252);

    n_hs = 0;
    out_ready = 1'b1;
    start_class(4);
    for (int c = 0; c < 50 && n_hs < 5; c++) begin
      @(posedge clk); #2;
    end
    rst_n = 1'b0;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_valid", int'(out_valid), 0);
    chk("arst_vec", int'(out_vec), 0);
    chk("arst_idx", int'(out_index), 0);
    chk("arst_last", int'(out_last), 0);
    @(posedge clk); #2;
    @(posedge clk); #2;
    rst_n = 1'b1;
    idle(1);
    start_class(2);
    chk("post_rst_vec", int'(out_vec), 'h003);
    chk("post_rst_idx", int'(out_index), 0);
    wait_class(1, 0, 500);
    idle(2);

    for (int v = 0; v < 1024; v++) seen_cnt[v] = 0;
    n_hs = 0;
    for (int kk = 0; kk <= 10; kk++) begin
      start_class(kk);
      wait_class(1, 1, 3000);
    end
    idle(3);
    chk("sweep_beats", n_hs, 1024);
    bad = 0;
    for (int v = 0; v < 1024; v++) begin
      if (seen_cnt[v] != 1) bad++;
    end
    chk("sweep_cover", bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
